// File: rtl/cpu_ctrl_if.sv
// Instruction handshake and control-output bundle for cpu_ctrl.
// The controller uses the slave side; the requester uses the master side.
interface cpu_ctrl_if #(
    parameter int INSTR_WIDTH = 20
);
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [1:0]             rf_raddr_a;
    logic [1:0]             rf_raddr_b;
    logic [1:0]             rf_waddr;
    logic                   rf_we;
    logic                   alu_func;
    logic                   alu_src_imm;
    logic [7:0]             imm;
    logic                   mem_re;
    logic                   mem_we;
    logic                   wb_sel_mem;
    logic                   done;
    logic [7:0]             retired_cnt;

    modport master (
        output instr, instr_valid,
        input  instr_ready, rf_raddr_a, rf_raddr_b,
        input  rf_waddr, rf_we, alu_func, alu_src_imm,
        input  imm, mem_re, mem_we, wb_sel_mem,
        input  done, retired_cnt
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, rf_raddr_a, rf_raddr_b,
        output rf_waddr, rf_we, alu_func, alu_src_imm,
        output imm, mem_re, mem_we, wb_sel_mem,
        output done, retired_cnt
    );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM: IDLE/DECODE/EXEC/MEM/WB with registered outputs.
// Outputs are computed from the next state so they line up with the state.
module cpu_ctrl #(
    parameter int INSTR_WIDTH = 20,
    parameter int MEM_WAIT    = 0
) (
    input logic       clk,
    input logic       rst,
    cpu_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    typedef enum logic [1:0] {
        C_NOP, C_ALU, C_LOAD, C_STORE
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic [1:0] x1;
        logic [1:0] x2;
        logic [1:0] x3;
        logic [7:0] imm;
        logic       func;
    } fields_t;

    typedef struct packed {
        logic       ready;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] wa;
        logic       we;
        logic       func;
        logic       src;
        logic [7:0] imm;
        logic       re;
        logic       mwe;
        logic       wbs;
        logic       done;
    } ctl_t;

    localparam logic [3:0] MW = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    fields_t    fld_q, fld_d;
    ctl_t       out_q, out_d;
    logic [7:0] ret_q;

    logic unused_bits;
    assign unused_bits = ^bus.instr[3:1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fld_d   = fld_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    fld_d.cls  = cls_t'(bus.instr[19:18]);
                    fld_d.x1   = bus.instr[17:16];
                    fld_d.x2   = bus.instr[15:14];
                    fld_d.x3   = bus.instr[13:12];
                    fld_d.imm  = bus.instr[11:4];
                    fld_d.func = bus.instr[0];
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (fld_q.cls == C_NOP) state_d = S_IDLE;
                else                    state_d = S_EXEC;
            end
            S_EXEC: begin
                if (fld_q.cls == C_ALU) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end
            end
            S_MEM: begin
                if (cnt_q == MW) begin
                    if (fld_q.cls == C_LOAD) state_d = S_WB;
                    else                     state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand setup is shared by EXEC, MEM and WB.
    always_comb begin
        out_d = '0;
        unique case (state_d)
            S_IDLE:   out_d.ready = 1'b1;
            S_DECODE: out_d.done  = (fld_d.cls == C_NOP);
            S_EXEC, S_MEM, S_WB: begin
                out_d.ra = fld_d.x2;
                unique case (1'b1)
                    fld_d.cls == C_ALU: begin
                        out_d.rb   = fld_d.x3;
                        out_d.func = fld_d.func;
                    end
                    fld_d.cls == C_STORE: begin
                        out_d.rb  = fld_d.x1;
                        out_d.src = 1'b1;
                        out_d.imm = fld_d.imm;
                    end
                    default: begin
                        out_d.src = 1'b1;
                        out_d.imm = fld_d.imm;
                    end
                endcase
                if (state_d == S_MEM) begin
                    out_d.re = (fld_d.cls == C_LOAD);
                    if (fld_d.cls == C_STORE && cnt_d == MW) begin
                        out_d.mwe  = 1'b1;
                        out_d.done = 1'b1;
                    end
                end
                if (state_d == S_WB) begin
                    out_d.wa   = fld_d.x1;
                    out_d.we   = 1'b1;
                    out_d.wbs  = (fld_d.cls == C_LOAD);
                    out_d.done = 1'b1;
                end
            end
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fld_q       <= '0;
            out_q       <= '0;
            out_q.ready <= 1'b1;
            ret_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fld_q   <= fld_d;
            out_q   <= out_d;
            ret_q   <= ret_q + 8'(out_q.done);
        end
    end

    assign bus.instr_ready = out_q.ready;
    assign bus.rf_raddr_a  = out_q.ra;
    assign bus.rf_raddr_b  = out_q.rb;
    assign bus.rf_waddr    = out_q.wa;
    assign bus.rf_we       = out_q.we;
    assign bus.alu_func    = out_q.func;
    assign bus.alu_src_imm = out_q.src;
    assign bus.imm         = out_q.imm;
    assign bus.mem_re      = out_q.re;
    assign bus.mem_we      = out_q.mwe;
    assign bus.wb_sel_mem  = out_q.wbs;
    assign bus.done        = out_q.done;
    assign bus.retired_cnt = ret_q;
endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: two instances (MEM_WAIT 0 and 2) checked every cycle
// against a per-instruction cycle-index model, plus literal spot checks.
module tb_cpu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] instr_tb = '0;
    logic        vld [2] = '{1'b0, 1'b0};

    cpu_ctrl_if #(.INSTR_WIDTH(20)) if0 ();
    cpu_ctrl_if #(.INSTR_WIDTH(20)) if1 ();

    assign if0.instr       = instr_tb;
    assign if1.instr       = instr_tb;
    assign if0.instr_valid = vld[0];
    assign if1.instr_valid = vld[1];

    cpu_ctrl #(.INSTR_WIDTH(20), .MEM_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );
    cpu_ctrl #(.INSTR_WIDTH(20), .MEM_WAIT(2)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [19:0] ALU1  = 20'b01000111000000000000;
    localparam logic [19:0] SUB1  = 20'b01110010000000000001;
    localparam logic [19:0] STO1  = 20'b11011000000011110000;
    localparam logic [19:0] LD1   = 20'b10111000000011110000;
    localparam logic [19:0] NOP1  = 20'b00000000000000000000;

    // Model: k = cycle index since acceptance (0 = idle), L = latency.
    int          mk  [2] = '{0, 0};
    int          mL  [2] = '{0, 0};
    logic [19:0] mwd [2] = '{20'd0, 20'd0};
    logic [7:0]  mcnt[2] = '{8'd0, 8'd0};
    int          mwt [2] = '{0, 2};

    function automatic int lat(logic [1:0] c, int w);
        case (c)
            2'b00:   return 1;
            2'b01:   return 3;
            2'b10:   return 4 + w;
            default: return 3 + w;
        endcase
    endfunction

    function automatic logic [29:0] expv(
        logic [19:0] w, int k, int L, int mw, logic [7:0] cnt
    );
        logic [1:0] c, x1, x2, x3, ra, rb, wa;
        logic       rdy, we, fn, src, re, mwe, wbs, dn;
        logic [7:0] im;
        c  = w[19:18];
        x1 = w[17:16];
        x2 = w[15:14];
        x3 = w[13:12];
        {ra, rb, wa} = '0;
        {rdy, we, fn, src, re, mwe, wbs, dn} = '0;
        im = '0;
        if (k == 0) begin
            rdy = 1'b1;
        end else begin
            dn = (k == L);
            if (k >= 2) begin
                ra = x2;
                if (c == 2'b01) begin
                    rb = x3;
                    fn = w[0];
                end else begin
                    src = 1'b1;
                    im  = w[11:4];
                    if (c == 2'b11) rb = x1;
                end
            end
            re  = (c == 2'b10) && k >= 3 && k <= 3 + mw;
            mwe = (c == 2'b11) && k == L;
            if ((c == 2'b01 || c == 2'b10) && k == L) begin
                wa  = x1;
                we  = 1'b1;
                wbs = (c == 2'b10);
            end
        end
        return {rdy, ra, rb, wa, we, fn, src, im, re, mwe, wbs, dn, cnt};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mk[i]   = 0;
                mcnt[i] = 8'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mk[i] == 0) begin
                    if (vld[i]) begin
                        mwd[i] = instr_tb;
                        mL[i]  = lat(instr_tb[19:18], mwt[i]);
                        mk[i]  = 1;
                    end
                end else if (mk[i] == mL[i]) begin
                    mk[i]   = 0;
                    mcnt[i] = mcnt[i] + 8'd1;
                end else begin
                    mk[i] = mk[i] + 1;
                end
            end
        end
    end

    logic [29:0] act [2];
    assign act[0] = {if0.instr_ready, if0.rf_raddr_a, if0.rf_raddr_b,
                     if0.rf_waddr, if0.rf_we, if0.alu_func,
                     if0.alu_src_imm, if0.imm, if0.mem_re, if0.mem_we,
                     if0.wb_sel_mem, if0.done, if0.retired_cnt};
    assign act[1] = {if1.instr_ready, if1.rf_raddr_a, if1.rf_raddr_b,
                     if1.rf_waddr, if1.rf_we, if1.alu_func,
                     if1.alu_src_imm, if1.imm, if1.mem_re, if1.mem_we,
                     if1.wb_sel_mem, if1.done, if1.retired_cnt};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [29:0] e;
            e = expv(mwd[i], mk[i], mL[i], mwt[i], mcnt[i]);
            checks++;
            if (act[i] !== e) begin
                errors++;
                $display("FAIL cycle dut%0d t=%0t got %h want %h",
                         i, $time, act[i], e);
            end
        end
    end

    task automatic chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // Called at a negedge with the target idle; returns #1 after acceptance.
    task automatic issue(int d, logic [19:0] w);
        instr_tb = w;
        vld[d]   = 1'b1;
        @(posedge clk);
        #1;
        vld[d]   = 1'b0;
        instr_tb = ~w;
    endtask

    task automatic wait_idle(int d);
        int t;
        t = 0;
        @(negedge clk);
        while (mk[d] != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", t < 40 ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    logic [19:0] extra [8] = '{
        20'b01101101000000000000, 20'b01011011000000000001,
        20'b10001100101010100000, 20'b11100100010101010000,
        20'b00111111111111111110, 20'b11111111111111111111,
        20'b10010011000000010000, 20'b01001001000000000001
    };

    int ndone;
    int rdy_in_done;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", if0.instr_ready, 1);
        chk("rst_cnt", if0.retired_cnt, 0);
        chk("rst_done", if1.done, 0);
        #2 rst = 1'b1;

        // LOAD aborted by reset in MEM.
        issue(0, LD1);
        repeat (3) @(negedge clk);
        chk("abort_mem_re", if0.mem_re, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_ready", if0.instr_ready, 1);
        chk("abort_mem_re_off", if0.mem_re, 0);
        @(negedge clk);
        chk("abort_we", if0.rf_we, 0);
        chk("abort_cnt", if0.retired_cnt, 0);
        #2 rst = 1'b1;

        // ALU add, accepted on the first edge after reset release.
        issue(0, ALU1);
        repeat (2) @(negedge clk);
        chk("add_ra", if0.rf_raddr_a, 1);
        chk("add_rb", if0.rf_raddr_b, 3);
        chk("add_we_c2", if0.rf_we, 0);
        @(negedge clk);
        chk("add_we", if0.rf_we, 1);
        chk("add_done", if0.done, 1);
        chk("add_wa", if0.rf_waddr, 0);
        chk("add_func", if0.alu_func, 0);
        @(negedge clk);
        chk("add_cnt", if0.retired_cnt, 1);
        chk("add_ready", if0.instr_ready, 1);

        issue(0, SUB1);
        repeat (3) @(negedge clk);
        chk("sub_done", if0.done, 1);
        chk("sub_func", if0.alu_func, 1);
        chk("sub_wa", if0.rf_waddr, 3);
        chk("sub_ra", if0.rf_raddr_a, 0);
        chk("sub_rb", if0.rf_raddr_b, 2);
        wait_idle(0);

        issue(0, LD1);
        repeat (3) @(negedge clk);
        chk("ld_re", if0.mem_re, 1);
        chk("ld_done_c3", if0.done, 0);
        @(negedge clk);
        chk("ld_we", if0.rf_we, 1);
        chk("ld_wbs", if0.wb_sel_mem, 1);
        chk("ld_wa", if0.rf_waddr, 3);
        chk("ld_re_wb", if0.mem_re, 0);
        wait_idle(0);
        chk("ld_cnt", if0.retired_cnt, 3);

        issue(1, STO1);
        repeat (2) @(negedge clk);
        chk("st_imm", if1.imm, 15);
        chk("st_ra", if1.rf_raddr_a, 2);
        chk("st_rb", if1.rf_raddr_b, 1);
        repeat (2) @(negedge clk);
        chk("st_we_c4", if1.mem_we, 0);
        @(negedge clk);
        chk("st_mwe", if1.mem_we, 1);
        chk("st_done", if1.done, 1);
        chk("st_rfwe", if1.rf_we, 0);
        wait_idle(1);

        foreach (extra[j]) begin
            issue(j % 2, extra[j]);
            wait_idle(j % 2);
            issue((j + 1) % 2, extra[j]);
            wait_idle((j + 1) % 2);
        end

        // 256 back-to-back NOPs from a fresh reset.
        do_reset();
        ndone       = 0;
        rdy_in_done = 0;
        instr_tb    = NOP1;
        vld[0]      = 1'b1;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (if0.done) begin
                ndone++;
                if (if0.instr_ready) rdy_in_done++;
            end
        end
        vld[0] = 1'b0;
        chk("nop_dones", ndone, 256);
        chk("nop_ready_decode", rdy_in_done, 0);
        chk("nop_wrap", if0.retired_cnt, 0);
        @(negedge clk);
        chk("nop_idle", if0.instr_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The block SHALL have parameter INSTR_WIDTH, default 20, giving the instruction word width.
REQ-002 The block SHALL have parameter MEM_WAIT, default 0, giving the extra MEM-state cycles before the memory access completes (0-15).
REQ-003 Port clk  input  1  system clock; every state change happens on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port instr  input  INSTR_WIDTH  instruction word, sampled only on acceptance.
REQ-006 Port instr_valid  input  1  requester has an instruction to issue.
REQ-007 Port instr_ready  output  1  controller can accept an instruction.
REQ-008 Port rf_raddr_a / rf_raddr_b  output  2 each  register-file read addresses.
REQ-009 Port rf_waddr  output  2, and port rf_we  output  1: register-file write address and write enable.
REQ-010 Port alu_func  output  1  selects the ALU operation: 0 = ADD, 1 = SUB.
REQ-011 Port alu_src_imm  output  1  selects the ALU B-operand source: 1 = imm, 0 = rf port B.
REQ-012 Port imm  output  8  address offset.
REQ-013 Port mem_re / mem_we  output  1 each  data-memory read and write strobes.
REQ-014 Port wb_sel_mem  output  1  selects the write-back source: 1 = memory, 0 = ALU.
REQ-015 Port done  output  1  one-cycle retire pulse.
REQ-016 Port retired_cnt  output  8  count of retired instructions.

Function
REQ-017 The instruction fields SHALL be: class=[19:18] (00 NOP, 01 ALU, 10 LOAD, 11 STORE), x1=[17:16], x2=[15:14], x3=[13:12], imm=[11:4], func=[0].
REQ-018 The FSM SHALL have states IDLE, DECODE, EXEC, MEM, WB; instr_ready SHALL be 1 only in IDLE.
REQ-019 An instruction SHALL be accepted on the rising edge where instr_valid=1 and instr_ready=1, with all fields latched and IDLE->DECODE; instr changes after acceptance SHALL be ignored.
REQ-020 Transitions SHALL be: DECODE->EXEC, except NOP, for which DECODE->IDLE with done=1 in DECODE.
REQ-021 Transitions SHALL be: EXEC->WB for ALU and EXEC->MEM for LOAD/STORE.
REQ-022 MEM SHALL last 1+MEM_WAIT cycles, counted by an internal counter cleared on MEM entry; MEM->WB for LOAD and MEM->IDLE for STORE.
REQ-023 WB SHALL last one cycle; WB->IDLE.
REQ-024 Latency from the acceptance edge to done SHALL be: NOP 1 cycle, ALU 3 cycles, STORE 3+MEM_WAIT cycles, LOAD 4+MEM_WAIT cycles.
REQ-025 For ALU: rf_raddr_a=x2, rf_raddr_b=x3, alu_func=func and alu_src_imm=0 in EXEC and WB; rf_waddr=x1, rf_we=1, wb_sel_mem=0 and done=1 in WB.
REQ-026 For LOAD: rf_raddr_a=x2, alu_src_imm=1, alu_func=0 and imm held from EXEC through WB; mem_re=1 in all MEM cycles; in WB rf_waddr=x1, rf_we=1, wb_sel_mem=1 and done=1.
REQ-027 For STORE: rf_raddr_a=x2, rf_raddr_b=x1, alu_src_imm=1 and alu_func=0 from EXEC through MEM; mem_we=1 only in the final MEM cycle, together with done=1.
REQ-028 rf_we, mem_we and done SHALL each be high for exactly one cycle per instruction that uses them; mem_re SHALL never be high together with mem_we.
REQ-029 Outputs not driven by the current state SHALL be 0.
REQ-030 retired_cnt SHALL increment on every rising edge where done=1, wrapping from 255 to 0.
REQ-031 A new instruction SHALL not be accepted in the done cycle; the earliest next acceptance is the cycle after done (IDLE).
REQ-032 In IDLE with instr_valid=0, state and all outputs SHALL hold.

Reset
REQ-033 When rst=0, the block SHALL immediately enter IDLE; outputs SHALL be: instr_ready=1, all strobes, addresses, imm, alu fields, done and retired_cnt 0, and the MEM wait counter 0.
REQ-034 A reset asserted mid-instruction SHALL abort it with no rf_we/mem_we pulse and no retired_cnt increment.
REQ-035 After rst returns to 1, the first acceptance SHALL be possible on the next rising edge.

Verification
REQ-036 Reset, then ALU instr 20'b01000111000000000000 -> rf_raddr_a=1, rf_raddr_b=3, rf_waddr=0, alu_func=0; rf_we=1 and done=1 in cycle 3; retired_cnt=1.
REQ-037 SUB 20'b01110010000000000001 -> alu_func=1, rf_waddr=3, rf_raddr_a=0, rf_raddr_b=2; done 3 cycles after acceptance.
REQ-038 STORE 20'b11011000000011110000 with MEM_WAIT=2 -> imm=15, rf_raddr_a=2, rf_raddr_b=1, mem_we=1 only in cycle 5, done in cycle 5, rf_we never 1.
REQ-039 LOAD 20'b10111000000011110000 with MEM_WAIT=0 -> mem_re=1 in cycle 3, rf_we=1, wb_sel_mem=1 and rf_waddr=3 in cycle 4.
REQ-040 rst=0 asserted during the LOAD MEM state -> immediate IDLE, no rf_we, retired_cnt unchanged; the next ALU instruction completes normally.
REQ-041 instr_valid held high for 256 NOPs -> each takes 2 cycles per acceptance, retired_cnt wraps to 0, and instr_ready=0 in every DECODE cycle.
